// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// Accepts two N-bit operands plus carry-in with a start/ready handshake, drives
// one external 1-bit full-adder cell LSB-first for N cycles, then publishes
// {cout, result} together with a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    input  logic         fa_sum,
    input  logic         fa_cout
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic           carry;
    logic [CW-1:0]  cnt;
    // Only the upper N-1 sum bits are ever needed: the lowest bit of a full
    // N-bit shifter would be shifted out before being read, so it is dropped.
    logic [N-2:0]   sum_sh;
    logic [N-1:0]   sum_next;

    assign sum_next = {fa_sum, sum_sh};

    // Cell inputs are driven only while a transaction is running.
    assign fa_a   = busy & a_sh[0];
    assign fa_b   = busy & b_sh[0];
    assign fa_cin = busy & carry;

    // Sequencer FSM: operand capture, bit-serial shifting, result publication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_sh <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_sh <= sum_next[N-1:1];
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (cnt == CW'(N - 1)) begin
                        cnt    <= '0;
                        result <= sum_next;
                        cout   <= fa_cout;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and table-driven bench for serial_add_ctrl,
// with behavioural full-adder cells, one N=8 instance and one N=2 instance.
module tb_serial_add_ctrl;

    logic       clk;
    logic       reset_n;

    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       fa_a;
    logic       fa_b;
    logic       fa_cin;
    logic       fa_sum;
    logic       fa_cout;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       ci2;
    logic       ready2;
    logic       busy2;
    logic       done2;
    logic [1:0] result2;
    logic       cout2;
    logic       fa_a2;
    logic       fa_b2;
    logic       fa_cin2;
    logic       fa_sum2;
    logic       fa_cout2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fa_a_tr;
    logic [7:0] fa_b_tr;
    logic [7:0] fa_cin_tr;
    logic [7:0] last_r;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] r;
        logic       co;
        logic [7:0] cin_tr;
    } vec_t;

    vec_t tbl[6];

    // Full-adder cells
    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign fa_sum2  = fa_a2 ^ fa_b2 ^ fa_cin2;
    assign fa_cout2 = (fa_a2 & fa_b2) | (fa_a2 & fa_cin2) | (fa_b2 & fa_cin2);

    serial_add_ctrl #(.N(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
        .cin(cin), .ready(ready), .busy(busy), .done(done), .result(result),
        .cout(cout), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    serial_add_ctrl #(.N(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .op_a(a2), .op_b(b2),
        .cin(ci2), .ready(ready2), .busy(busy2), .done(done2), .result(result2),
        .cout(cout2), .fa_a(fa_a2), .fa_b(fa_b2), .fa_cin(fa_cin2),
        .fa_sum(fa_sum2), .fa_cout(fa_cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present operands, let the next edge accept them, then scramble inputs.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        last_r = result;
        op_a   = a;
        op_b   = b;
        cin    = ci;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        op_a   = ~a;
        op_b   = 8'($urandom);
        cin    = ~ci;
    endtask

    // Called one step after the accept edge; follows the transaction to ready.
    task automatic finish8(input logic [7:0] er, input logic ec, input logic [7:0] prev_r);
        int   nb;
        logic held;
        nb = 0;
        held = 1'b1;
        fa_a_tr = '0;
        fa_b_tr = '0;
        fa_cin_tr = '0;
        while (busy === 1'b1 && nb < 20) begin
            if (nb < 8) begin
                fa_a_tr[nb]   = fa_a;
                fa_b_tr[nb]   = fa_b;
                fa_cin_tr[nb] = fa_cin;
            end
            if (result !== prev_r) held = 1'b0;
            nb++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(nb), 32'd8);
        check("result_held_in_run", 32'(held), 32'd1);
        check("done_pulse", 32'(done), 32'd1);
        check("result", 32'(result), 32'(er));
        check("cout", 32'(cout), 32'(ec));
        check("fa_zero_in_done", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_back", 32'(ready), 32'd1);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic ci);
        int         nb;
        logic [2:0] exp;
        exp = 3'(a) + 3'(b) + 3'(ci);
        a2 = a;
        b2 = b;
        ci2 = ci;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        a2 = ~a;
        b2 = ~b;
        ci2 = ~ci;
        nb = 0;
        while (busy2 === 1'b1 && nb < 10) begin
            nb++;
            @(posedge clk); #1;
        end
        check("n2_busy_cycles", 32'(nb), 32'd2);
        check("n2_done_pulse", 32'(done2), 32'd1);
        check("n2_sum", 32'({cout2, result2}), 32'(exp));
        @(posedge clk); #1;
        check("n2_done_one_cycle", 32'(done2), 32'd0);
        check("n2_ready_back", 32'(ready2), 32'd1);
    endtask

    initial begin
        logic [8:0] exp9;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int         idle;

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 8'h00};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFE};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 8'h01};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 8'h01};

        reset_n = 1'b0;
        start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_result_cout", 32'({cout, result}), 32'd0);
        check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven transactions, including cell-drive traces
        for (int i = 0; i < 6; i++) begin
            launch8(tbl[i].a, tbl[i].b, tbl[i].ci);
            finish8(tbl[i].r, tbl[i].co, last_r);
            check("fa_a_trace", 32'(fa_a_tr), 32'(tbl[i].a));
            check("fa_b_trace", 32'(fa_b_tr), 32'(tbl[i].b));
            check("fa_cin_trace", 32'(fa_cin_tr), 32'(tbl[i].cin_tr));
        end

        // start held high through RUN and the done cycle with other operands
        last_r = result;
        op_a = 8'h35; op_b = 8'h4A; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        op_a = 8'hAA; op_b = 8'h11; cin = 1'b1;
        finish8(8'h7F, 1'b0, last_r);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        check("result_after_ignored", 32'({cout, result}), 32'h07F);
        @(posedge clk); #1;
        check("start_at_ready_accepted", 32'(busy), 32'd1);
        start = 1'b0;
        finish8(8'hBC, 1'b0, 8'h7F);

        // Reset in the 4th RUN cycle
        launch8(8'h35, 8'h4A, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrun_rst_ready", 32'(ready), 32'd1);
        check("midrun_rst_busy_done", 32'({busy, done}), 32'd0);
        check("midrun_rst_result", 32'({cout, result}), 32'd0);
        check("midrun_rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("no_done_after_reset", 32'({done, busy}), 32'd0);
        end
        launch8(8'h12, 8'h34, 1'b0);
        finish8(8'h46, 1'b0, 8'h00);

        // Random sweep with idle gaps
        for (int t = 0; t < 200; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            launch8(ra, rb, rc);
            finish8(exp9[7:0], exp9[8], last_r);
            idle = int'($urandom_range(0, 3));
            repeat (idle) begin
                @(posedge clk); #1;
            end
            check("result_held_idle", 32'({cout, result}), 32'(exp9));
        end

        // N=2 instance, exhaustive
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    run2(2'(a), 2'(b), 1'(c));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
